// File: rtl/ps2_sender_pkg.sv
// Shared types and constants for the PS/2 device-side key sender.
package ps2_sender_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } ps2_state_e;

  localparam logic       PS2_START = 1'b0;
  localparam logic       PS2_STOP  = 1'b1;
  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  // Frame bit i is sent as the i-th bit: start, data LSB first, odd parity, stop.
  function automatic logic [10:0] ps2_frame(input logic [7:0] b);
    return {PS2_STOP, ~^b, b, PS2_START};
  endfunction

endpackage

// File: rtl/ps2_halfbit_timer.sv
// Loadable down-counter; tick_o pulses for one cycle every PERIOD enabled cycles.
module ps2_halfbit_timer #(
  parameter int PERIOD = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [W-1:0] RELOAD = W'(PERIOD - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = RELOAD;
    end else if (en_i) begin
      cnt_d = (cnt_q == '0) ? RELOAD : cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= RELOAD;
    else       cnt_q <= cnt_d;
  end

  assign tick_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/ps2_key_sender.sv
// PS/2 keyboard device emulator: serializes handshaked scan codes into 11-bit frames.
// Define PS2_AUTO_BREAK_EN to append F0 + repeated byte (break code) after each make code.
module ps2_key_sender
  import ps2_sender_pkg::*;
#(
  parameter int clk_mhz     = 25,
  parameter int ps2_half_us = 40,
  parameter int gap_us      = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       ps2clk,
  output logic       ps2data,
  output logic       busy
);

  localparam int HALF_CYC = clk_mhz * ps2_half_us;
  localparam int GAP_CYC  = clk_mhz * gap_us;
  localparam logic [3:0] LAST_BIT = 4'd10;

  ps2_state_e  state_q, state_d;
  logic [10:0] frame_q, frame_d;
  logic [3:0]  bit_q, bit_d;
  logic        clk_q, clk_d, dat_q, dat_d, rdy_q, rdy_d, busy_q, busy_d;
  logic        hs, half_load, half_tick, gap_load, gap_tick;
`ifdef PS2_AUTO_BREAK_EN
  logic [1:0]  seq_q, seq_d;
  logic [7:0]  byte_q, byte_d;
`endif

  function automatic logic [3:0] bit_sat_inc(input logic [3:0] b);
    return (b >= LAST_BIT) ? LAST_BIT : b + 4'd1;
  endfunction

  assign hs = tx_valid && rdy_q;

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    bit_d     = bit_q;
    clk_d     = clk_q;
    dat_d     = dat_q;
    rdy_d     = rdy_q;
    busy_d    = busy_q;
    half_load = 1'b0;
    gap_load  = 1'b0;
`ifdef PS2_AUTO_BREAK_EN
    seq_d     = seq_q;
    byte_d    = byte_q;
`endif
    case (state_q)
      IDLE: begin
        if (hs) begin
          frame_d   = ps2_frame(tx_data);
          bit_d     = '0;
          half_load = 1'b1;
          clk_d     = 1'b1;
          dat_d     = PS2_START;
          rdy_d     = 1'b0;
          busy_d    = 1'b1;
          state_d   = SHIFT;
`ifdef PS2_AUTO_BREAK_EN
          seq_d     = 2'd0;
          byte_d    = tx_data;
`endif
        end
      end
      SHIFT: begin
        // High phase ends in a falling edge; low phase ends by presenting the next bit.
        if (half_tick) begin
          if (clk_q) begin
            clk_d = 1'b0;
          end else if (bit_q == LAST_BIT) begin
            clk_d    = 1'b1;
            dat_d    = 1'b1;
            gap_load = 1'b1;
            state_d  = GAP;
          end else begin
            bit_d = bit_sat_inc(bit_q);
            dat_d = frame_q[bit_d];
            clk_d = 1'b1;
          end
        end
      end
      GAP: begin
        if (gap_tick) begin
`ifdef PS2_AUTO_BREAK_EN
          if (seq_q == 2'd0 && byte_q != PS2_BREAK && byte_q != PS2_EXT) begin
            frame_d   = ps2_frame(PS2_BREAK);
            seq_d     = 2'd1;
            bit_d     = '0;
            half_load = 1'b1;
            dat_d     = PS2_START;
            state_d   = SHIFT;
          end else if (seq_q == 2'd1) begin
            frame_d   = ps2_frame(byte_q);
            seq_d     = 2'd2;
            bit_d     = '0;
            half_load = 1'b1;
            dat_d     = PS2_START;
            state_d   = SHIFT;
          end else begin
            rdy_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
`else
          rdy_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      bit_q   <= '0;
      clk_q   <= 1'b1;
      dat_q   <= 1'b1;
      rdy_q   <= 1'b1;
      busy_q  <= 1'b0;
`ifdef PS2_AUTO_BREAK_EN
      seq_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      clk_q   <= clk_d;
      dat_q   <= dat_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
`ifdef PS2_AUTO_BREAK_EN
      seq_q   <= seq_d;
`endif
    end
  end

  // Frame payload is only read after a load in IDLE/GAP, so it needs no reset.
  always_ff @(posedge clk) begin
    frame_q <= frame_d;
`ifdef PS2_AUTO_BREAK_EN
    byte_q  <= byte_d;
`endif
  end

  ps2_halfbit_timer #(.PERIOD(HALF_CYC)) u_half_tmr (
    .clk_i  (clk),
    .rst_i  (reset),
    .load_i (half_load),
    .en_i   (state_q == SHIFT),
    .tick_o (half_tick)
  );

  ps2_halfbit_timer #(.PERIOD(GAP_CYC)) u_gap_tmr (
    .clk_i  (clk),
    .rst_i  (reset),
    .load_i (gap_load),
    .en_i   (state_q == GAP),
    .tick_o (gap_tick)
  );

  assign tx_ready = rdy_q;
  assign ps2clk   = clk_q;
  assign ps2data  = dat_q;
  assign busy     = busy_q;

endmodule

// File: doc/ps2_key_sender.md
# ps2_key_sender

Emulates the device side of a PS/2 keyboard link. It accepts scan-code bytes over a valid/ready handshake and serializes each one as an 11-bit PS/2 frame on generated clock and data lines. It sits between an autotype/script source (or the RS-232 bridge) and the `ps2clk`/`ps2data` inputs of the `orao` core, replacing the fixed-button keystroke hack on boards without a keyboard.

## Interface
Parameters:
- `clk_mhz`, 25: system clock frequency in MHz.
- `ps2_half_us`, 40: PS/2 clock half-period in µs, giving a 12.5 kHz link. H = clk_mhz*ps2_half_us cycles.
- `gap_us`, 200: inter-frame idle time in µs. G = clk_mhz*gap_us cycles.

Ports:
- `clk` in 1: system clock, same as the core clock (`clk_pixel` at top).
- `reset` in 1: asynchronous, active-high.
- `tx_data` in 8: scan code to send.
- `tx_valid` in 1: `tx_data` is valid.
- `tx_ready` out 1: block can accept a byte; a byte transfers on a `clk` edge where `tx_valid && tx_ready`.
- `ps2clk` out 1: PS/2 clock, idle high.
- `ps2data` out 1: PS/2 data, idle high.
- `busy` out 1: a frame or gap is in progress.

## Operation
- States: IDLE, SHIFT, GAP.
- IDLE: `tx_ready`=1. On handshake, latch the frame, clear the bit index and half-period counter, and go to SHIFT.
- Frame layout, sent in order: start 0, `tx_data[0]`..`tx_data[7]` (LSB first), odd parity (= ~^tx_data), stop 1.
- SHIFT: each bit spans 2H cycles.
  - First H cycles: `ps2data`=bit, `ps2clk`=1.
  - Next H cycles: `ps2clk`=0.
  - Data changes only while `ps2clk` is high, so the receiver samples on the falling edge.
- After the 11th bit's low phase, go to GAP with `ps2clk`=1 and `ps2data`=1. Stay for G cycles, then return to IDLE.
- `tx_valid` seen outside IDLE is ignored and not queued. The source holds it.
- All outputs are registered.
- Half-period counter width is $clog2(H). Bit index is 4 bits and saturates at 10.

## Timing
- Reset values: `ps2clk`=1, `ps2data`=1, `tx_ready`=1, `busy`=0, state IDLE.
- The cycle after the handshake: `ps2data`=0 (start bit), `busy`=1, `tx_ready`=0.
- First falling edge of `ps2clk` comes H cycles after the start bit appears.
- SHIFT lasts 22H cycles and GAP lasts G cycles.
- Minimum handshake-to-handshake spacing is 22H+G+1 cycles.
- Reset asserted mid-frame: lines go high and state returns to IDLE immediately. The partial frame is abandoned and is not resent.
- `tx_valid` asserted in the same cycle reset deasserts: the handshake may complete on the first edge after reset.

## Configuration
- Macro `PS2_AUTO_BREAK_EN`.
- Defined: after a frame whose byte is neither 8'hE0 nor 8'hF0, the block appends the break sequence internally:
  - GAP, then frame 8'hF0, then GAP, then frame of the same byte, then GAP, then IDLE.
  - `tx_ready` stays 0 throughout.
  - A state SEQ (or a 2-bit sequence counter) selects the next byte.
- Undefined: exactly one frame is sent per handshake, and the source sends its own F0 codes.

## Structure
- Package `ps2_sender_pkg` holds:
  - state enum (IDLE, SHIFT, GAP);
  - `PS2_START`=0, `PS2_STOP`=1;
  - `PS2_BREAK`=8'hF0, `PS2_EXT`=8'hE0.
- One sub-module, `ps2_halfbit_timer`: a loadable down-counter producing a one-cycle `tick` every H (or G) cycles.
- Expected RTL: about 150–250 lines.

## Test plan
The bench uses clk_mhz=1, ps2_half_us=4, gap_us=10, so H=4 and G=10.
- Reset: release reset, then `ps2clk`=1, `ps2data`=1, `tx_ready`=1, `busy`=0; no line toggles for 100 cycles.
- Byte 8'h32 ("B" key): sampled on the 11 falling edges of `ps2clk` gives 0,0,1,0,0,1,1,0,0,0,1 (parity 0). Exactly 11 falling edges, 88 cycles, then 10 idle cycles, then `tx_ready`=1.
- Byte 8'h00: parity bit 1. Frame reads 0,0,0,0,0,0,0,0,0,1,1.
- Back-to-back: hold `tx_valid` with 8'h21, then 8'h5A. The second handshake occurs exactly 99 cycles after the first, and both frames decode correctly.
- Reset mid-frame: assert reset during bit 4. `ps2clk` and `ps2data` read 1 in the same cycle, and a new 8'h5A after reset is sent cleanly.
- With `PS2_AUTO_BREAK_EN`: 8'h21 gives frames 21, F0, 21, with `tx_ready`=0 until 3·88+3·10 cycles after the first start bit. 8'hF0 gives a single frame.
